// File: rtl/regfile_pkg.sv
// Shared constants and bundle types for the register-file write-back path.
// Holds widths, the hard-wired zero register index and the request bundle.
package regfile_pkg;

  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  localparam logic [ADDR_W-1:0] ZERO_REG = ADDR_W'(31);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard for RAW hazard detection on two read addresses.
// Ports: claim (set), clr (clear on rf write), chk_addrA/B -> hazardA/B.
module wb_scoreboard
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              claim_valid,
  input  logic [ADDR_W-1:0] claim_addr,
  input  logic              clr_valid,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] chk_addrA,
  input  logic [ADDR_W-1:0] chk_addrB,
  output logic              hazardA,
  output logic              hazardB
);

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] clr_vec;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (claim_valid && claim_addr != ZERO_REG)
      set_vec = NUM_REGS'(1) << claim_addr;
    if (clr_valid)
      clr_vec = NUM_REGS'(1) << clr_addr;
  end

  // set is applied after clear so a same-cycle claim survives
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      pending <= '0;
    else
      pending <= (pending & ~clr_vec) | set_vec;
  end

  assign hazardA = pending[chk_addrA];
  assign hazardB = pending[chk_addrB];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter for the register file's single write port.
// Ports: req0/req1 valid-ready requests, registered write/wrAddr/wrData,
// claim/chk scoreboard interface, hazardA/B; conflict_cnt with WB_ARB_STATS_EN.
module regfile_wb_arbiter
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              write,
  output logic [ADDR_W-1:0] wrAddr,
  output logic [DATA_W-1:0] wrData,
  input  logic              claim_valid,
  input  logic [ADDR_W-1:0] claim_addr,
  input  logic [ADDR_W-1:0] chk_addrA,
  input  logic [ADDR_W-1:0] chk_addrB,
`ifdef WB_ARB_STATS_EN
  output logic [31:0]       conflict_cnt,
`endif
  output logic              hazardA,
  output logic              hazardB
);

  logic    last;
  logic    xfer;
  logic    gnt1;
  logic    keep;
  wb_req_t req0;
  wb_req_t req1;
  wb_req_t sel;

  assign req0 = '{addr: req0_addr, data: req0_data};
  assign req1 = '{addr: req1_addr, data: req1_data};

  // on conflict the requester that did not win last time gets the port
  assign req0_ready = req0_valid & (~req1_valid | last);
  assign req1_ready = req1_valid & (~req0_valid | ~last);

  assign xfer = req0_ready | req1_ready;
  assign gnt1 = req1_ready;
  assign sel  = gnt1 ? req1 : req0;
  assign keep = xfer && (sel.addr != ZERO_REG);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last   <= 1'b1;
      write  <= 1'b0;
      wrAddr <= '0;
      wrData <= '0;
    end else begin
      write <= keep;
      if (xfer)
        last <= gnt1;
      if (keep) begin
        wrAddr <= sel.addr;
        wrData <= sel.data;
      end
    end
  end

`ifdef WB_ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      conflict_cnt <= '0;
    else if (req0_valid && req1_valid && conflict_cnt != '1)
      conflict_cnt <= conflict_cnt + 32'd1;
  end
`endif

  wb_scoreboard u_sb (
    .clk         (clk),
    .reset       (reset),
    .claim_valid (claim_valid),
    .claim_addr  (claim_addr),
    .clr_valid   (write),
    .clr_addr    (wrAddr),
    .chk_addrA   (chk_addrA),
    .chk_addrB   (chk_addrB),
    .hazardA     (hazardA),
    .hazardB     (hazardB)
  );

endmodule
